// File: rtl/bcd_seven_seg_scanner.sv
// Purpose : latch a packed 8-digit BCD result and sign, decode it to seven-segment
//           patterns and scan them onto a multiplexed common-anode display.
// Latency : capture edge -> held regs; +1 edge -> patterns/flags; +1 edge -> seg/anode.
// Flow    : no backpressure; FLAG_output is a pure capture qualifier, every
//           sampled-high edge overwrites the held value (last one wins).
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   FLAG_output  upstream result valid (capture qualifier)
//   decimal      packed BCD, digit k at [4k+3:4k], digit 7 most significant
//   negative     sign of the value, 1 = negative
//   anode        digit enables, active-low, bit k = digit k
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   overflow     negative value but no free position left for the minus sign
//   bcd_error    held value contains a digit greater than 9

module bcd_seven_seg_scanner #(
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        FLAG_output,
   input  logic [31:0] decimal,
   input  logic        negative,
   output logic [7:0]  anode,
   output logic [6:0]  seg,
   output logic        overflow,
   output logic        bcd_error
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_ERR   = 7'h06;

   // Active-low glyphs; anything above 9 renders as 'E'.
   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'h40;
         4'd1:    g = 7'h79;
         4'd2:    g = 7'h24;
         4'd3:    g = 7'h30;
         4'd4:    g = 7'h19;
         4'd5:    g = 7'h12;
         4'd6:    g = 7'h02;
         4'd7:    g = 7'h78;
         4'd8:    g = 7'h00;
         4'd9:    g = 7'h10;
         default: g = SEG_ERR;
      endcase
      return g;
   endfunction

   // ---------------------------------------------------------------------
   // Capture stage. Upstream zeroes 'decimal' while its flag is low, so the
   // held copy is only touched on qualified edges.
   // ---------------------------------------------------------------------
   logic [31:0] held_dec;
   logic        held_neg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         held_dec <= 32'd0;
         held_neg <= 1'b0;
      end else if (FLAG_output) begin
         held_dec <= decimal;
         held_neg <= negative;
      end
   end

   // ---------------------------------------------------------------------
   // Decode stage: leading-digit search, blanking, minus placement, flags.
   // ---------------------------------------------------------------------
   logic [2:0] lead;
   logic [6:0] pat_nxt [8];
   logic [6:0] pat_q   [8];
   logic       ovf_nxt;
   logic       err_nxt;

   always_comb begin
      // Highest nonzero digit wins; an all-zero value leaves lead at 0 so
      // digit 0 is always lit.
      lead = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (held_dec[4*k +: 4] != 4'd0) lead = 3'(k);
      end

      err_nxt = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if ((BLANK_LZ != 0) && (3'(k) > lead)) pat_nxt[k] = SEG_BLANK;
         else                                  pat_nxt[k] = glyph(held_dec[4*k +: 4]);
         if (held_dec[4*k +: 4] > 4'd9) err_nxt = 1'b1;
      end

      // The minus sign goes just left of the leading digit, which is always a
      // blank position when blanking is on and lead < 7. Without blanking, or
      // with all eight digits in use, there is nowhere to put it.
      ovf_nxt = 1'b0;
      if (held_neg) begin
         if ((BLANK_LZ != 0) && (lead != 3'd7)) pat_nxt[lead + 3'd1] = SEG_MINUS;
         else                                   ovf_nxt = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 8; k++) pat_q[k] <= SEG_BLANK;
         overflow  <= 1'b0;
         bcd_error <= 1'b0;
      end else begin
         for (int k = 0; k < 8; k++) pat_q[k] <= pat_nxt[k];
         overflow  <= ovf_nxt;
         bcd_error <= err_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Scan: slot counter and digit index.
   // ---------------------------------------------------------------------
   logic [CW-1:0] slot_cnt;
   logic [2:0]    digit_idx;
   logic          slot_end;
   logic          in_guard;

   assign slot_end = (slot_cnt == CW'(SCAN_DIV - 1));
   assign in_guard = (slot_cnt < CW'(GUARD));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_cnt  <= '0;
         digit_idx <= 3'd0;
      end else if (slot_end) begin
         slot_cnt  <= '0;
         digit_idx <= digit_idx + 3'd1;
      end else begin
         slot_cnt  <= slot_cnt + CW'(1);
      end
   end

   // Registered pin drivers, one cycle behind the counter. The guard window
   // at the start of each slot keeps every anode dark while the segment
   // lines settle to the next digit, which suppresses ghosting.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         anode <= 8'hFF;
         seg   <= SEG_BLANK;
      end else if (in_guard) begin
         anode <= 8'hFF;
         seg   <= SEG_BLANK;
      end else begin
         anode <= ~(8'b1 << digit_idx);
         seg   <= pat_q[digit_idx];
      end
   end

endmodule
